pmu_wrlock_ctrl: RTL
====================

PMU_WRLOCK_CTRL -- requirements
Module: pmu_wrlock_ctrl

Interface
REQ-001 Parameter NREG, default 4, number of lock-protected PMU registers (1..32).
REQ-002 Parameter KEY_W, default 32, key width in bits.
REQ-003 Parameter KEY, default 32'h0051_F15E, unlock key value.
REQ-004 Parameter WINDOW, default 8, unlock window length in cycles (1..255).
REQ-005 Parameter CNT_W, default 8, violation counter width.
REQ-006 clock  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 io_key_write_valid  in  1  key register write strobe.
REQ-009 io_key_write_data  in  KEY_W  key value written.
REQ-010 io_regs_write_valid  in  NREG  per-register write request, bit i = register i.
REQ-011 io_debug_mode  in  1  debug-mode indication; never grants write access.
REQ-012 io_lockdown_set  in  1  request permanent lockdown until reset.
REQ-013 io_regs_write_en  out  NREG  granted write enables, combinational from current state and inputs.
REQ-014 io_unlocked  out  1  high while state is ARMED.
REQ-015 io_lockdown  out  1  high while state is LOCKDOWN.
REQ-016 io_viol_count  out  CNT_W  saturating count of rejected accesses.
REQ-017 io_viol_pulse  out  1  registered one-cycle pulse, one cycle after any violation.

Function
REQ-018 FSM states: LOCKED, ARMED, LOCKDOWN; a window counter of ceil(log2(WINDOW+1)) bits.
REQ-019 io_regs_write_en SHALL equal io_regs_write_valid when state is ARMED and exactly one valid bit is set; otherwise all zero.
REQ-020 io_debug_mode SHALL have no effect on grants, state, or counter.
REQ-021 LOCKED + key write with data == KEY -> ARMED next cycle, window counter loaded with WINDOW.
REQ-022 LOCKED + key write with data != KEY -> stay LOCKED, violation.
REQ-023 LOCKED + any io_regs_write_valid bit set -> no grant, violation.
REQ-024 ARMED + single-bit register write (granted) -> LOCKED next cycle (one write per unlock).
REQ-025 ARMED + multi-bit register write -> no grant, LOCKED next cycle, violation.
REQ-026 ARMED + no access -> counter decrements; at value 1 the next state is LOCKED, so io_unlocked stays high exactly WINDOW cycles.
REQ-027 ARMED + correct key (with or without a same-cycle register write) -> stay ARMED, counter reloaded with WINDOW; the same-cycle single write is still granted.
REQ-028 ARMED + wrong key -> LOCKED next cycle, violation; a same-cycle single write is still granted.
REQ-029 io_lockdown_set in any state -> LOCKDOWN next cycle, overriding all other transitions.
REQ-030 Same-cycle grant under REQ-019 is unaffected by io_lockdown_set.
REQ-031 LOCKDOWN is exited only by reset; key writes are ignored.
REQ-032 In LOCKDOWN, any register write request is a violation.
REQ-033 At most one violation is counted per cycle, whatever its cause.
REQ-034 io_viol_count increments by 1 per violation cycle and saturates at 2^CNT_W-1 (no wrap).
REQ-035 io_viol_pulse is high in cycle t+1 if and only if a violation occurred in cycle t.

Reset
REQ-036 While reset is high: state LOCKED, window counter 0, io_viol_count 0, io_viol_pulse 0, io_unlocked 0, io_lockdown 0, io_regs_write_en 0.
REQ-037 Reset asserted mid-window or in LOCKDOWN SHALL return the block to LOCKED immediately, without waiting for a clock edge.

Verification
REQ-038 Key 0x0051F15E, then write valid=4'b0010 next cycle -> io_regs_write_en=4'b0010, io_unlocked=0 the following cycle, io_viol_count=0.
REQ-039 Key correct, no writes -> io_unlocked high exactly 8 cycles; write valid=4'b0001 at cycle 9 -> en=0, count=1, pulse at cycle 10.
REQ-040 io_debug_mode=1, state LOCKED, write valid=4'b1000 -> en=0, count increments to 1.
REQ-041 ARMED, write valid=4'b0011 -> en=0, state LOCKED, count=1; ARMED + wrong key 0x0 -> LOCKED, count=2.
REQ-042 io_lockdown_set pulse, then correct key and writes -> io_lockdown=1, io_unlocked stays 0, every write counted; reset -> LOCKED, count 0.
REQ-043 With CNT_W=2, 5 locked write attempts -> io_viol_count=3 after the third and stays 3.

Source files
------------

// File: rtl/pmu_wrlock_if.sv
// Write-lock bus for the PMU register guard: key writes, per-register write
// requests, lockdown request, and the resulting grants and status.
interface pmu_wrlock_if #(
    parameter int NREG  = 4,
    parameter int KEY_W = 32,
    parameter int CNT_W = 8
);
    logic             io_key_write_valid;
    logic [KEY_W-1:0] io_key_write_data;
    logic [NREG-1:0]  io_regs_write_valid;
    logic             io_debug_mode;
    logic             io_lockdown_set;
    logic [NREG-1:0]  io_regs_write_en;
    logic             io_unlocked;
    logic             io_lockdown;
    logic [CNT_W-1:0] io_viol_count;
    logic             io_viol_pulse;

    modport master (
        output io_key_write_valid, io_key_write_data, io_regs_write_valid,
               io_debug_mode, io_lockdown_set,
        input  io_regs_write_en, io_unlocked, io_lockdown, io_viol_count,
               io_viol_pulse
    );

    modport slave (
        input  io_key_write_valid, io_key_write_data, io_regs_write_valid,
               io_debug_mode, io_lockdown_set,
        output io_regs_write_en, io_unlocked, io_lockdown, io_viol_count,
               io_viol_pulse
    );
endinterface

// File: rtl/pmu_wrlock_ctrl.sv
// PMU register write-lock: a key opens a time-limited window for exactly one
// register write; rejected accesses are counted and lockdown holds until reset.
module pmu_wrlock_ctrl #(
    parameter int               NREG   = 4,
    parameter int               KEY_W  = 32,
    parameter logic [KEY_W-1:0] KEY    = 32'h0051_F15E,
    parameter int               WINDOW = 8,
    parameter int               CNT_W  = 8
) (
    input logic        clock,
    input logic        reset,
    pmu_wrlock_if.slave bus
);
    localparam int               WIN_W    = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        ARMED    = 2'd1,
        LOCKDOWN = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIN_W-1:0] win_r;
    logic             unlocked_r;
    logic             lockdown_r;
    logic [CNT_W-1:0] viol_cnt_r;
    logic             viol_pulse_r;

    logic             any_wr_s;
    logic             single_s;
    logic             multi_s;
    logic             key_ok_s;
    logic             key_bad_s;
    logic             viol_s;
    logic [NREG-1:0]  grant_s;
    logic             unused_debug_s;

    function automatic logic is_onehot(input logic [NREG-1:0] v);
        return (v != '0) && ((v & (v - NREG'(1))) == '0);
    endfunction

    // Debug mode is deliberately ignored: it must never widen write access.
    assign unused_debug_s = bus.io_debug_mode;

    // Decode the current access and classify violations for this cycle.
    always_comb begin
        any_wr_s  = |bus.io_regs_write_valid;
        single_s  = is_onehot(bus.io_regs_write_valid);
        multi_s   = any_wr_s && !single_s;
        key_ok_s  = bus.io_key_write_valid && (bus.io_key_write_data == KEY);
        key_bad_s = bus.io_key_write_valid && (bus.io_key_write_data != KEY);
        viol_s    = 1'b0;
        case (state_r)
            LOCKED:   viol_s = any_wr_s || key_bad_s;
            ARMED:    viol_s = multi_s || key_bad_s;
            LOCKDOWN: viol_s = any_wr_s;
            default:  viol_s = 1'b0;
        endcase
        if ((state_r == ARMED) && single_s) begin
            grant_s = bus.io_regs_write_valid;
        end else begin
            grant_s = '0;
        end
    end

    // Lock FSM, unlock window, violation counter and registered status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= LOCKED;
            win_r        <= '0;
            unlocked_r   <= 1'b0;
            lockdown_r   <= 1'b0;
            viol_cnt_r   <= '0;
            viol_pulse_r <= 1'b0;
        end else begin
            viol_pulse_r <= viol_s;
            if (viol_s && (viol_cnt_r != CNT_MAX)) begin
                viol_cnt_r <= viol_cnt_r + CNT_W'(1);
            end else begin
                viol_cnt_r <= viol_cnt_r;
            end

            if (bus.io_lockdown_set) begin
                state_r    <= LOCKDOWN;
                win_r      <= '0;
                unlocked_r <= 1'b0;
                lockdown_r <= 1'b1;
            end else begin
                case (state_r)
                    LOCKED: begin
                        if (key_ok_s) begin
                            state_r    <= ARMED;
                            win_r      <= WIN_LOAD;
                            unlocked_r <= 1'b1;
                        end else begin
                            state_r    <= LOCKED;
                            win_r      <= '0;
                            unlocked_r <= 1'b0;
                        end
                        lockdown_r <= 1'b0;
                    end
                    ARMED: begin
                        // Any write, multi-bit abuse or bad key consumes the unlock.
                        if (multi_s || key_bad_s || (single_s && !key_ok_s)) begin
                            state_r    <= LOCKED;
                            win_r      <= '0;
                            unlocked_r <= 1'b0;
                        end else if (key_ok_s) begin
                            state_r    <= ARMED;
                            win_r      <= WIN_LOAD;
                            unlocked_r <= 1'b1;
                        end else if (win_r <= WIN_W'(1)) begin
                            state_r    <= LOCKED;
                            win_r      <= '0;
                            unlocked_r <= 1'b0;
                        end else begin
                            state_r    <= ARMED;
                            win_r      <= win_r - WIN_W'(1);
                            unlocked_r <= 1'b1;
                        end
                        lockdown_r <= 1'b0;
                    end
                    LOCKDOWN: begin
                        state_r    <= LOCKDOWN;
                        win_r      <= '0;
                        unlocked_r <= 1'b0;
                        lockdown_r <= 1'b1;
                    end
                    default: begin
                        state_r    <= LOCKED;
                        win_r      <= '0;
                        unlocked_r <= 1'b0;
                        lockdown_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.io_regs_write_en = grant_s;
    assign bus.io_unlocked      = unlocked_r;
    assign bus.io_lockdown      = lockdown_r;
    assign bus.io_viol_count    = viol_cnt_r;
    assign bus.io_viol_pulse    = viol_pulse_r;
endmodule
